// File: rtl/pixel_fifo_pkg.sv
// Shared types for the PPU pixel FIFO and the sprite mixer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package pixel_fifo_pkg;

    // Default slot geometry used by fifo_slot_t.
    localparam int DEF_PIX_W  = 2;
    localparam int DEF_ATTR_W = 2;

    typedef enum logic {
        FIFO_QUEUE = 1'b0,
        FIFO_MERGE = 1'b1
    } fifo_mode_e;

    // Colour index 0 never reaches the screen; a merge may overwrite it.
    localparam logic [DEF_PIX_W-1:0] TRANSPARENT_PIX = '0;

    // The colour index sits in the low bits so that the transparency test
    // is a simple low-field compare on a flat slot vector.
    typedef struct packed {
        logic [DEF_ATTR_W-1:0] attr;
        logic [DEF_PIX_W-1:0]  pix;
    } fifo_slot_t;

    // A merge always leaves at least one full row queued.
    function automatic int unsigned merge_extent(input int unsigned occ,
                                                 input int unsigned row);
        return (occ > row) ? occ : row;
    endfunction

endpackage

// File: rtl/row_merge_unit.sv
// Overlays a freshly fetched row onto the ROW slots at the head of a queue.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the write enables are used.
//
// Ports:
//   old_slots_i    ROW existing slots, slot i at [i*SLOT_W +: SLOT_W], {attr,pix}
//   occupancy_i    number of live slots; slots at index >= occupancy are free
//   new_pixels_i   new row, pixel i at [i*PIX_W +: PIX_W]
//   new_attr_i     attributes for every pixel of the new row
//   merged_slots_o resulting slots (equal to old where not written)
//   slot_we_o      per-slot write enable
module row_merge_unit
    import pixel_fifo_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ATTR_W = DEF_ATTR_W,
    parameter int ROW    = 8,
    parameter int OCC_W  = 5
) (
    input  logic [ROW*(PIX_W+ATTR_W)-1:0] old_slots_i,
    input  logic [OCC_W-1:0]              occupancy_i,
    input  logic [ROW*PIX_W-1:0]          new_pixels_i,
    input  logic [ATTR_W-1:0]             new_attr_i,
    output logic [ROW*(PIX_W+ATTR_W)-1:0] merged_slots_o,
    output logic [ROW-1:0]                slot_we_o
);

    localparam int SLOT_W = PIX_W + ATTR_W;
    localparam logic [PIX_W-1:0] CLEAR_PIX = PIX_W'(TRANSPARENT_PIX);

    always_comb begin
        merged_slots_o = old_slots_i;
        slot_we_o      = '0;
        for (int i = 0; i < ROW; i++) begin
            // Free slot, or an occupied one showing transparent colour: the
            // new pixel goes in. Otherwise the older (lower-X) pixel wins.
            if ((occupancy_i <= OCC_W'(i)) ||
                (old_slots_i[i*SLOT_W +: PIX_W] == CLEAR_PIX)) begin
                merged_slots_o[i*SLOT_W +: SLOT_W] = {new_attr_i, new_pixels_i[i*PIX_W +: PIX_W]};
                slot_we_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_row_fifo.sv
// Pixel queue between the BG/sprite fetchers and the mixer: rows in, pixels out.
// Latency: 1 cycle from an accepted pop to pixel_valid_out; rows visible next cycle.
// Backpressure: queue mode stalls rows until ROW slots are free; merge mode stalls on a pop.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   tclk_in                 T-cycle enable gating pops
//   merge_mode_in           0 = append rows, 1 = overlay rows onto the head
//   flush_in                synchronous clear, beats push and pop
//   push_valid_in / push_ready_out / push_pixels_in / push_attr_in   row input
//   pop_in                  mixer pixel request
//   pixel_out / attr_out / pixel_valid_out                           pixel output
//   occupancy_out / empty_out                                        fill status
module pixel_row_fifo
    import pixel_fifo_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ATTR_W = DEF_ATTR_W,
    parameter int ROW    = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       tclk_in,
    input  logic                       merge_mode_in,
    input  logic                       flush_in,
    input  logic                       push_valid_in,
    output logic                       push_ready_out,
    input  logic [ROW*PIX_W-1:0]       push_pixels_in,
    input  logic [ATTR_W-1:0]          push_attr_in,
    input  logic                       pop_in,
    output logic [PIX_W-1:0]           pixel_out,
    output logic [ATTR_W-1:0]          attr_out,
    output logic                       pixel_valid_out,
    output logic [$clog2(DEPTH):0]     occupancy_out,
    output logic                       empty_out
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int SLOT_W = PIX_W + ATTR_W;

    // Slot storage: {attr, pix} per entry, deliberately not reset.
    logic [SLOT_W-1:0] slot_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q,    occ_d;
    logic [PIX_W-1:0]  pix_q,    pix_d;
    logic [ATTR_W-1:0] attr_q,   attr_d;
    logic              valid_q,  valid_d;

    fifo_mode_e        mode;
    logic              pop_fire;
    logic              push_fire;
    logic              queue_push;
    logic              merge_push;
    logic [OCC_W-1:0]  free_slots;
    logic [OCC_W-1:0]  merge_len;
    logic [SLOT_W-1:0] head_slot;

    logic [ROW*SLOT_W-1:0] head_row;
    logic [ROW*SLOT_W-1:0] merged_row;
    logic [ROW-1:0]        merge_we;

    assign mode = merge_mode_in ? FIFO_MERGE : FIFO_QUEUE;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign pop_fire   = tclk_in & pop_in & (occ_q != '0);
    assign free_slots = OCC_W'(DEPTH) - occ_q;

    // Queue mode judges space on pre-pop occupancy, so a concurrent pop never
    // feeds back into ready. Merge mode rewrites the head slots the pop would
    // read, so the two are kept apart.
    always_comb begin
        if (mode == FIFO_MERGE) begin
            push_ready_out = ~pop_fire;
        end else begin
            push_ready_out = (free_slots >= OCC_W'(ROW));
        end
    end

    assign push_fire  = push_valid_in & push_ready_out;
    assign queue_push = push_fire & ~flush_in & (mode == FIFO_QUEUE);
    assign merge_push = push_fire & ~flush_in & (mode == FIFO_MERGE);

    // ------------------------------------------------------------------
    // Merge datapath: the ROW slots starting at the read pointer
    // ------------------------------------------------------------------
    always_comb begin
        head_row = '0;
        for (int i = 0; i < ROW; i++) begin
            head_row[i*SLOT_W +: SLOT_W] = slot_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    row_merge_unit #(
        .PIX_W  (PIX_W),
        .ATTR_W (ATTR_W),
        .ROW    (ROW),
        .OCC_W  (OCC_W)
    ) u_merge (
        .old_slots_i    (head_row),
        .occupancy_i    (occ_q),
        .new_pixels_i   (push_pixels_in),
        .new_attr_i     (push_attr_in),
        .merged_slots_o (merged_row),
        .slot_we_o      (merge_we)
    );

    assign merge_len = OCC_W'(merge_extent(32'(occ_q), 32'(ROW)));
    assign head_slot = slot_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        pix_d    = pix_q;
        attr_d   = attr_q;
        valid_d  = 1'b0;

        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (pop_fire) begin
                pix_d    = head_slot[PIX_W-1:0];
                attr_d   = head_slot[SLOT_W-1:PIX_W];
                valid_d  = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                occ_d    = occ_q - 1'b1;
            end
            if (queue_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(ROW);
                occ_d    = occ_d + OCC_W'(ROW);
            end
            // merge_push excludes pop_fire, so rd_ptr_q/occ_q are current.
            if (merge_push) begin
                wr_ptr_d = rd_ptr_q + merge_len[PTR_W-1:0];
                occ_d    = merge_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            pix_q    <= '0;
            attr_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            pix_q    <= pix_d;
            attr_q   <= attr_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < ROW; i++) begin
            if (queue_push) begin
                slot_q[wr_ptr_q + PTR_W'(i)] <= {push_attr_in, push_pixels_in[i*PIX_W +: PIX_W]};
            end else if (merge_push && merge_we[i]) begin
                slot_q[rd_ptr_q + PTR_W'(i)] <= merged_row[i*SLOT_W +: SLOT_W];
            end
        end
    end

    assign pixel_out       = pix_q;
    assign attr_out        = attr_q;
    assign pixel_valid_out = valid_q;
    assign occupancy_out   = occ_q;
    assign empty_out       = (occ_q == '0);

endmodule

// File: tb/tb_pixel_row_fifo.sv
// Bench for pixel_row_fifo: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a queue-based model.
module tb_pixel_row_fifo;
    import pixel_fifo_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        tclk_in = 1'b0;
    logic        merge_mode_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        push_valid_in = 1'b0;
    logic        push_ready_out;
    logic [15:0] push_pixels_in = '0;
    logic [1:0]  push_attr_in = '0;
    logic        pop_in = 1'b0;
    logic [1:0]  pixel_out;
    logic [1:0]  attr_out;
    logic        pixel_valid_out;
    logic [4:0]  occupancy_out;
    logic        empty_out;

    pixel_row_fifo #(.PIX_W(2), .ATTR_W(2), .ROW(8), .DEPTH(16)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tclk_in         (tclk_in),
        .merge_mode_in   (merge_mode_in),
        .flush_in        (flush_in),
        .push_valid_in   (push_valid_in),
        .push_ready_out  (push_ready_out),
        .push_pixels_in  (push_pixels_in),
        .push_attr_in    (push_attr_in),
        .pop_in          (pop_in),
        .pixel_out       (pixel_out),
        .attr_out        (attr_out),
        .pixel_valid_out (pixel_valid_out),
        .occupancy_out   (occupancy_out),
        .empty_out       (empty_out)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the FIFO contents as a plain queue, head = front.
    // ------------------------------------------------------------------
    fifo_slot_t mq[$];
    logic       m_valid = 1'b0;
    logic [1:0] m_pix   = '0;
    logic [1:0] m_attr  = '0;

    always @(negedge clk_in) begin
        bit         pf;
        bit         rdy;
        fifo_slot_t s;
        if (rst_in) begin
            mq.delete();
            m_valid = 1'b0;
            m_pix   = '0;
            m_attr  = '0;
        end
        pf  = tclk_in && pop_in && (mq.size() != 0);
        rdy = merge_mode_in ? !pf : ((16 - mq.size()) >= 8);

        chk("occupancy", int'(occupancy_out), mq.size());
        chk("empty", int'(empty_out), int'(mq.size() == 0));
        chk("push_ready", int'(push_ready_out), int'(rdy));
        chk("pixel_valid", int'(pixel_valid_out), int'(m_valid));
        if (m_valid) begin
            chk("pixel", int'(pixel_out), int'(m_pix));
            chk("attr", int'(attr_out), int'(m_attr));
        end

        if (!rst_in) begin
            if (flush_in) begin
                mq.delete();
                m_valid = 1'b0;
            end else begin
                if (pf) begin
                    s       = mq.pop_front();
                    m_pix   = s.pix;
                    m_attr  = s.attr;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                if (push_valid_in && rdy) begin
                    for (int i = 0; i < 8; i++) begin
                        s.pix  = push_pixels_in[i*2 +: 2];
                        s.attr = push_attr_in;
                        if (merge_mode_in) begin
                            if (i >= mq.size()) mq.push_back(s);
                            else if (mq[i].pix == 2'd0) mq[i] = s;
                        end else begin
                            mq.push_back(s);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_row(input logic [15:0] row, input logic [1:0] attr);
        push_valid_in  = 1'b1;
        push_pixels_in = row;
        push_attr_in   = attr;
        step();
        push_valid_in  = 1'b0;
    endtask

    // Literal expectations
    int wrap_pix  [12] = '{0, 1, 2, 3, 3, 3, 2, 2, 1, 1, 0, 0};
    int wrap_attr [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2};
    int mrg_pix   [8]  = '{2, 3, 1, 3, 3, 3, 3, 3};
    int mrg_attr  [8]  = '{0, 3, 0, 3, 3, 3, 3, 3};

    initial begin
        #2 rst_in = 1'b1;
        #1;
        chk("rst_occ", int'(occupancy_out), 0);
        chk("rst_valid", int'(pixel_valid_out), 0);
        chk("rst_pixel", int'(pixel_out), 0);
        chk("rst_attr", int'(attr_out), 0);
        chk("rst_empty", int'(empty_out), 1);
        chk("rst_ready", int'(push_ready_out), 1);
        step();
        step();
        rst_in = 1'b0;

        // Two identical rows fill the queue exactly.
        push_row(16'hE4E4, 2'd0);
        push_row(16'hE4E4, 2'd0);
        chk("full_occ", int'(occupancy_out), 16);
        chk("full_ready", int'(push_ready_out), 0);
        tclk_in = 1'b1;
        pop_in  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            chk("seq_valid", int'(pixel_valid_out), 1);
            chk("seq_pixel", int'(pixel_out), k % 4);
        end
        step();
        chk("drained_valid", int'(pixel_valid_out), 0);
        pop_in = 1'b0;

        // Wrap: 2 rows, 12 pops, 1 more row across the pointer wrap.
        push_row(16'hE4E4, 2'd0);
        push_row(16'hE4E4, 2'd1);
        pop_in = 1'b1;
        repeat (12) step();
        pop_in = 1'b0;
        chk("wrap_occ4", int'(occupancy_out), 4);
        push_row(16'h05AF, 2'd2);
        pop_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("wrap_valid", int'(pixel_valid_out), 1);
            chk("wrap_pixel", int'(pixel_out), wrap_pix[k]);
            chk("wrap_attr", int'(attr_out), wrap_attr[k]);
        end
        chk("wrap_occ0", int'(occupancy_out), 0);
        step();
        chk("underflow_valid", int'(pixel_valid_out), 0);
        pop_in = 1'b0;

        // Merge: leave {2,0,1} queued, overlay a row of 3s with attr 3.
        push_row(16'h4BFF, 2'd0);
        pop_in = 1'b1;
        repeat (5) step();
        pop_in = 1'b0;
        chk("pre_merge_occ", int'(occupancy_out), 3);
        merge_mode_in = 1'b1;
        push_row(16'hFFFF, 2'd3);
        chk("merge_occ", int'(occupancy_out), 8);
        pop_in         = 1'b1;
        push_valid_in  = 1'b1;
        push_pixels_in = 16'hFFFF;
        push_attr_in   = 2'd1;
        #1;
        chk("merge_pop_ready", int'(push_ready_out), 0);
        step();
        push_valid_in = 1'b0;
        chk("merge_pop_occ", int'(occupancy_out), 7);
        chk("merge_pixel", int'(pixel_out), mrg_pix[0]);
        chk("merge_attr", int'(attr_out), mrg_attr[0]);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("merge_pixel", int'(pixel_out), mrg_pix[k]);
            chk("merge_attr", int'(attr_out), mrg_attr[k]);
        end
        pop_in = 1'b0;
        step();
        merge_mode_in = 1'b0;

        // Push + pop together at occupancy 8, then blocked at 9.
        push_row(16'h1234, 2'd1);
        push_valid_in = 1'b1;
        pop_in        = 1'b1;
        step();
        push_valid_in = 1'b0;
        pop_in        = 1'b0;
        chk("pushpop_occ15", int'(occupancy_out), 15);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        push_row(16'h1111, 2'd0);
        push_row(16'h2222, 2'd1);
        pop_in = 1'b1;
        repeat (7) step();
        chk("occ9", int'(occupancy_out), 9);
        push_valid_in = 1'b1;
        #1;
        chk("occ9_ready", int'(push_ready_out), 0);
        step();
        push_valid_in = 1'b0;
        pop_in        = 1'b0;
        chk("occ9_pop_occ", int'(occupancy_out), 8);

        // Flush beats a simultaneous push and pop.
        flush_in      = 1'b1;
        push_valid_in = 1'b1;
        pop_in        = 1'b1;
        push_pixels_in = 16'hFFFF;
        step();
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        pop_in        = 1'b0;
        chk("flush_occ", int'(occupancy_out), 0);
        chk("flush_valid", int'(pixel_valid_out), 0);
        push_row(16'h05AF, 2'd2);
        pop_in = 1'b1;
        step();
        pop_in = 1'b0;
        chk("post_flush_pixel", int'(pixel_out), 3);
        chk("post_flush_attr", int'(attr_out), 2);

        // Asynchronous reset in mid-cycle with 8 pixels queued.
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        push_row(16'hE4E4, 2'd0);
        push_row(16'hE4E4, 2'd0);
        pop_in = 1'b1;
        repeat (8) step();
        pop_in = 1'b0;
        chk("pre_rst_occ", int'(occupancy_out), 8);
        chk("pre_rst_valid", int'(pixel_valid_out), 1);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_occ", int'(occupancy_out), 0);
        chk("async_rst_valid", int'(pixel_valid_out), 0);
        chk("async_rst_ready", int'(push_ready_out), 1);
        step();
        rst_in = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (!push_valid_in && ($urandom_range(0, 99) < 3)) begin
                merge_mode_in = ~merge_mode_in;
                push_valid_in = 1'b0;
            end else begin
                push_valid_in = ($urandom_range(0, 99) < 30);
            end
            push_pixels_in = 16'($urandom);
            push_attr_in   = 2'($urandom_range(0, 3));
            pop_in         = ($urandom_range(0, 99) < 60);
            tclk_in        = ($urandom_range(0, 99) < 70);
            flush_in       = ($urandom_range(0, 99) < 1);
            step();
        end
        push_valid_in = 1'b0;
        pop_in        = 1'b0;
        flush_in      = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
